event_trigger_mapper: RTL and testbench
=======================================

# event_trigger_mapper

Decodes the received EVR event-code stream into per-output trigger strobes that feed the `triggerStrobe` input of each output driver. A 256-entry map RAM associates every event code with a bitmask of triggers. Each trigger has a programmable prescaler, so it fires on the first matching event and then on every Nth one. The block sits in the `evrClk` domain between the event receiver and the bank of output drivers; configuration arrives as already-synchronized CSR words.

## Interface
- `TRIGGER_COUNT`, 8 — number of trigger outputs (1..16)
- `EVCODE_WIDTH`, 8 — event-code width; map depth is 2^EVCODE_WIDTH
- `PRESCALE_WIDTH`, 16 — prescaler divisor width
- `CSR_DATA_BUS_WIDTH`, 32 — configuration word width

- `evrClk`  in  1  event clock; the only clock of the block
- `evrReset`  in  1  reset, synchronous, active-high
- `evCode`  in  EVCODE_WIDTH  received event code
- `evCodeValid`  in  1  `evCode` is valid this cycle
- `cfgStrobe`  in  1  one-cycle configuration write strobe
- `cfgData`  in  CSR_DATA_BUS_WIDTH  configuration word
- `cntSelect`  in  4  trigger index for the counter readback
- `cntValue`  out  32  selected trigger counter
- `busy`  out  1  map clear sweep in progress
- `triggerStrobe`  out  TRIGGER_COUNT  one-cycle trigger pulses to the output drivers

## Operation
- Opcode is `cfgData[31:30]`.
  - 00 SET_MAP: code = `[23:16]`, mask = `[TRIGGER_COUNT-1:0]`.
  - 01 SET_PRESCALE: trigger index = `[27:24]`, divisor = `[PRESCALE_WIDTH-1:0]`. A divisor of 0 is treated as 1.
  - 10 CLEAR_COUNTERS.
  - 11 is ignored.
- Event code 0 is the null code. It never matches anything, and SET_MAP to code 0 is ignored.
- SET_PRESCALE with an index ≥ TRIGGER_COUNT is ignored.
- FSM states are CLEAR and RUN.
  - Reset enters CLEAR. The sweep writes mask 0 to addresses 0..2^EVCODE_WIDTH-1, one per cycle, then moves to RUN.
  - `busy` is high only while in CLEAR.
  - In CLEAR, SET_MAP writes are dropped, `triggerStrobe` is held at 0, and SET_PRESCALE and CLEAR_COUNTERS are still honoured.
- Prescaler, one per trigger, holding a divisor D and a countdown C.
  - On a matching event: if C==0 the trigger fires and C←D-1; otherwise C←C-1.
  - SET_PRESCALE loads D and sets C←0, so the next match fires.
  - Reset sets D=1 and C=0 for every trigger.
- Reset values: `triggerStrobe`=0, `cntValue`=0, `busy`=1 in the first cycle after reset.
- Reset asserted mid-operation discards any in-flight lookups and restarts the sweep.

## Timing
- Lookup pipeline:
  - edge N: `evCode`/`evCodeValid` sampled
  - edge N+1: map RAM read data registered
  - edge N+2: prescale decision, `triggerStrobe` registered high for exactly one cycle
- Fixed latency is 2 cycles.
- Back-to-back valid codes on consecutive cycles are all processed. Throughput is one event per cycle.
- A SET_MAP to the same address as a same-cycle lookup is read-before-write: the lookup uses the old mask. The new mask applies from the next sampled event.
- SET_PRESCALE in the same cycle as a prescale decision for that trigger: the configuration write wins, the strobe is suppressed that cycle, and C←0.
- `cntValue` is registered and follows `cntSelect` one cycle later. A `cntSelect` ≥ TRIGGER_COUNT reads 0.

## Configuration
- Macro `EVENT_TRIGGER_COUNTERS_EN`.
- Defined: each trigger has a 32-bit count of fired strobes.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset and by CLEAR_COUNTERS.
  - CLEAR_COUNTERS in the same cycle as a fire leaves the count at 0.
- Undefined: no counters are built, `cntValue` is tied to 0, and CLEAR_COUNTERS is ignored.

## Structure
- Shared package `evr_trigger_pkg`:
  - opcode constants (`OP_SET_MAP`, `OP_SET_PRESCALE`, `OP_CLEAR_COUNTERS`)
  - `EVCODE_NULL` = 0
  - opcode field bit positions
  - FSM state enum
- Sub-module `event_map_ram`:
  - 2^EVCODE_WIDTH × TRIGGER_COUNT
  - one write port, one registered read port, read-before-write
  - infers block RAM

## Test plan
- Reset, then wait: `busy` is high for 256 cycles, then low. A code 0x10 sent during the sweep produces no strobe.
- SET_MAP 0x10→0x05, then send 0x10 at edge N: `triggerStrobe`=0x05 for the single cycle after edge N+2. Code 0x11 produces nothing. SET_MAP 0x00→0xFF has no effect when code 0 is sent.
- SET_PRESCALE trigger 0 with D=3, then 7 consecutive 0x10 events: trigger 0 fires on events 1, 4 and 7. Trigger 2 fires on all 7.
- SET_MAP 0x10→0x02 in the same cycle as sampling code 0x10 (old mask 0x05): that event gives 0x05, the next gives 0x02.
- With `EVENT_TRIGGER_COUNTERS_EN`, after the prescale scenario: `cntSelect`=0 reads 3 and `cntSelect`=2 reads 7. After CLEAR_COUNTERS both read 0. Without the macro, `cntValue` is always 0.
- Assert reset mid-burst: no strobe appears in the 2 cycles after reset, and all divisors read back as 1 (every match fires).

Source files
------------

// File: rtl/evr_trigger_pkg.sv
// Shared constants and types for the EVR event-to-trigger mapper.
package evr_trigger_pkg;

  localparam logic [1:0] OP_SET_MAP        = 2'b00;
  localparam logic [1:0] OP_SET_PRESCALE   = 2'b01;
  localparam logic [1:0] OP_CLEAR_COUNTERS = 2'b10;

  localparam int unsigned EVCODE_NULL  = 0;

  // Configuration word field positions
  localparam int unsigned OPCODE_LSB   = 30;
  localparam int unsigned MAP_CODE_LSB = 16;
  localparam int unsigned PS_INDEX_LSB = 24;
  localparam int unsigned PS_INDEX_W   = 4;
  localparam int unsigned COUNT_W      = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } trig_state_e;

endpackage

// File: rtl/event_map_ram.sv
// Event-code to trigger-mask map: one write port, one registered read-before-write read port.
module event_map_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/event_trigger_mapper.sv
// Maps received event codes to prescaled one-cycle trigger strobes.
// Optional per-trigger fire counters are built when EVENT_TRIGGER_COUNTERS_EN is defined.
module event_trigger_mapper
  import evr_trigger_pkg::*;
#(
  parameter int unsigned TRIGGER_COUNT      = 8,
  parameter int unsigned EVCODE_WIDTH       = 8,
  parameter int unsigned PRESCALE_WIDTH     = 16,
  parameter int unsigned CSR_DATA_BUS_WIDTH = 32
) (
  input  logic                          evrClk,
  input  logic                          evrReset,
  input  logic [EVCODE_WIDTH-1:0]       evCode,
  input  logic                          evCodeValid,
  input  logic                          cfgStrobe,
  input  logic [CSR_DATA_BUS_WIDTH-1:0] cfgData,
  input  logic [3:0]                    cntSelect,
  output logic [31:0]                   cntValue,
  output logic                          busy,
  output logic [TRIGGER_COUNT-1:0]      triggerStrobe
);

  localparam int unsigned TC = TRIGGER_COUNT;
  localparam int unsigned PW = PRESCALE_WIDTH;
  localparam int unsigned EW = EVCODE_WIDTH;

  trig_state_e state_q, state_d;
  logic [EW-1:0] sweep_q, sweep_d;
  logic          busy_q;

  logic [1:0]            op_c;
  logic [EW-1:0]         cfg_code_c;
  logic [PS_INDEX_W-1:0] ps_idx_c;
  logic [PW-1:0]         ps_div_c;
  logic                  map_wr_c, ps_wr_c, cnt_clr_c;

  logic          ram_we_c;
  logic [EW-1:0] ram_waddr_c;
  logic [TC-1:0] ram_wdata_c, ram_rdata;

  logic          lk_valid_q;
  logic [TC-1:0] mask_q;
  logic [PW-1:0] div_q [TC];
  logic [PW-1:0] div_d [TC];
  logic [PW-1:0] cd_q  [TC];
  logic [PW-1:0] cd_d  [TC];
  logic [TC-1:0] fire_c, strobe_q;

  // Configuration word decode
  assign op_c       = cfgData[OPCODE_LSB +: 2];
  assign cfg_code_c = cfgData[MAP_CODE_LSB +: EW];
  assign ps_idx_c   = cfgData[PS_INDEX_LSB +: PS_INDEX_W];
  assign ps_div_c   = (cfgData[PW-1:0] == '0) ? PW'(1) : cfgData[PW-1:0];
  assign map_wr_c   = cfgStrobe && (op_c == OP_SET_MAP) && (cfg_code_c != EW'(EVCODE_NULL));
  assign ps_wr_c    = cfgStrobe && (op_c == OP_SET_PRESCALE) && (32'(ps_idx_c) < TC);
  assign cnt_clr_c  = cfgStrobe && (op_c == OP_CLEAR_COUNTERS);

  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      busy_q  <= (state_d == ST_CLEAR);
    end
  end

  // CLEAR owns the RAM write port to sweep every address to zero; RUN takes SET_MAP writes
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    ram_we_c    = 1'b0;
    ram_waddr_c = cfg_code_c;
    ram_wdata_c = cfgData[TC-1:0];
    unique case (state_q)
      ST_CLEAR: begin
        ram_we_c    = 1'b1;
        ram_waddr_c = sweep_q;
        ram_wdata_c = '0;
        sweep_d     = sweep_q + EW'(1);
        if (sweep_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ram_we_c = map_wr_c;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  event_map_ram #(
    .ADDR_W (EW),
    .DATA_W (TC)
  ) u_map_ram (
    .clk_i   (evrClk),
    .we_i    (ram_we_c),
    .waddr_i (ram_waddr_c),
    .wdata_i (ram_wdata_c),
    .raddr_i (evCode),
    .rdata_o (ram_rdata)
  );

  // Lookups are only accepted in RUN; the null code never matches
  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      lk_valid_q <= 1'b0;
      mask_q     <= '0;
    end else begin
      lk_valid_q <= evCodeValid && (evCode != EW'(EVCODE_NULL)) && (state_q == ST_RUN);
      mask_q     <= lk_valid_q ? ram_rdata : '0;
    end
  end

  // Prescale decision; a same-cycle SET_PRESCALE wins over the match
  always_comb begin
    for (int unsigned t = 0; t < TC; t++) begin
      div_d[t]  = div_q[t];
      cd_d[t]   = cd_q[t];
      fire_c[t] = 1'b0;
      if (ps_wr_c && (32'(ps_idx_c) == t)) begin
        div_d[t] = ps_div_c;
        cd_d[t]  = '0;
      end else if (mask_q[t]) begin
        if (cd_q[t] == '0) begin
          fire_c[t] = (state_q == ST_RUN);
          cd_d[t]   = div_q[t] - PW'(1);
        end else begin
          cd_d[t] = cd_q[t] - PW'(1);
        end
      end
    end
  end

  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      for (int unsigned t = 0; t < TC; t++) begin
        div_q[t] <= PW'(1);
        cd_q[t]  <= '0;
      end
      strobe_q <= '0;
    end else begin
      for (int unsigned t = 0; t < TC; t++) begin
        div_q[t] <= div_d[t];
        cd_q[t]  <= cd_d[t];
      end
      strobe_q <= fire_c;
    end
  end

  assign triggerStrobe = strobe_q;
  assign busy          = busy_q;

`ifdef EVENT_TRIGGER_COUNTERS_EN
  logic [COUNT_W-1:0] cnt_q [TC];
  logic [COUNT_W-1:0] cnt_d [TC];
  logic [COUNT_W-1:0] sel_cnt_c;
  logic [COUNT_W-1:0] cnt_value_q;

  // Saturating fire counters; a clear beats a same-cycle fire
  always_comb begin
    sel_cnt_c = '0;
    for (int unsigned t = 0; t < TC; t++) begin
      cnt_d[t] = cnt_q[t];
      if (cnt_clr_c) begin
        cnt_d[t] = '0;
      end else if (fire_c[t] && (cnt_q[t] != '1)) begin
        cnt_d[t] = cnt_q[t] + COUNT_W'(1);
      end
      if (32'(cntSelect) == t) begin
        sel_cnt_c = cnt_q[t];
      end
    end
  end

  always_ff @(posedge evrClk) begin
    if (evrReset) begin
      for (int unsigned t = 0; t < TC; t++) begin
        cnt_q[t] <= '0;
      end
      cnt_value_q <= '0;
    end else begin
      for (int unsigned t = 0; t < TC; t++) begin
        cnt_q[t] <= cnt_d[t];
      end
      cnt_value_q <= sel_cnt_c;
    end
  end

  assign cntValue = cnt_value_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^{cntSelect, cnt_clr_c};
  assign cntValue   = '0;
`endif

  logic unused_cfg;
  assign unused_cfg = ^cfgData;

endmodule

// File: tb/tb_event_trigger_mapper.sv
// Randomized self-checking bench for event_trigger_mapper against a match-count reference model.
module tb_event_trigger_mapper;

  localparam int TC = 8;

  logic          evrClk = 1'b0;
  logic          evrReset = 1'b1;
  logic [7:0]    evCode = '0;
  logic          evCodeValid = 1'b0;
  logic          cfgStrobe = 1'b0;
  logic [31:0]   cfgData = '0;
  logic [3:0]    cntSelect = '0;
  logic [31:0]   cntValue;
  logic          busy;
  logic [TC-1:0] triggerStrobe;

  always #5 evrClk = ~evrClk;

  event_trigger_mapper #(
    .TRIGGER_COUNT      (TC),
    .EVCODE_WIDTH       (8),
    .PRESCALE_WIDTH     (16),
    .CSR_DATA_BUS_WIDTH (32)
  ) dut (
    .evrClk        (evrClk),
    .evrReset      (evrReset),
    .evCode        (evCode),
    .evCodeValid   (evCodeValid),
    .cfgStrobe     (cfgStrobe),
    .cfgData       (cfgData),
    .cntSelect     (cntSelect),
    .cntValue      (cntValue),
    .busy          (busy),
    .triggerStrobe (triggerStrobe)
  );

  // Reference model: a trigger fires when its match count since the last divisor load is a multiple of D
  logic [TC-1:0] m_map [256];
  int unsigned   m_div [TC];
  int unsigned   m_k   [TC];
  int unsigned   m_cnt [TC];
  logic [TC-1:0] m_dly0, m_dly1;
  int            m_clr_left;

  int errors = 0;
  int checks = 0;
  logic [TC-1:0] last_strobe;
  logic [31:0]   last_cnt;
  logic          last_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 256; a++) m_map[a] = '0;
    for (int t = 0; t < TC; t++) begin
      m_div[t] = 1;
      m_k[t]   = 0;
      m_cnt[t] = 0;
    end
    m_dly0 = '0;
    m_dly1 = '0;
    m_clr_left = 256;
  endtask

  function automatic logic [31:0] set_map(input logic [7:0] c, input logic [7:0] m);
    return {2'b00, 6'b0, c, 8'h00, m};
  endfunction

  function automatic logic [31:0] set_ps(input logic [3:0] idx, input logic [15:0] d);
    return {2'b01, 2'b00, idx, 8'h00, d};
  endfunction

  function automatic logic [31:0] clr_cnt();
    return {2'b10, 30'b0};
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare outputs after it
  task automatic step(input logic rst, input logic [7:0] code, input logic vld,
                      input logic cs, input logic [31:0] cd, input logic [3:0] sel);
    logic [TC-1:0] exp_strobe, m_in, dec;
    logic [31:0]   exp_cnt;
    logic          exp_busy, running;
    logic [1:0]    op;
    evrReset = rst; evCode = code; evCodeValid = vld;
    cfgStrobe = cs; cfgData = cd; cntSelect = sel;
    op = cd[31:30];
    exp_strobe = '0;
    exp_cnt = '0;
    if (rst) begin
      model_reset();
      exp_busy = 1'b1;
    end else begin
      running = (m_clr_left == 0);
      m_in = (vld && code != 8'h00 && running) ? m_map[code] : '0;
      dec = m_dly1;
      m_dly1 = m_dly0;
      m_dly0 = m_in;
`ifdef EVENT_TRIGGER_COUNTERS_EN
      exp_cnt = (int'(sel) < TC) ? m_cnt[sel] : 32'd0;
`endif
      for (int t = 0; t < TC; t++) begin
        if (cs && op == 2'b01 && int'(cd[27:24]) == t) begin
          m_div[t] = (cd[15:0] == 16'd0) ? 1 : int'(cd[15:0]);
          m_k[t] = 0;
        end else if (dec[t]) begin
          exp_strobe[t] = (m_k[t] % m_div[t] == 0);
          m_k[t]++;
        end
`ifdef EVENT_TRIGGER_COUNTERS_EN
        if (cs && op == 2'b10) m_cnt[t] = 0;
        else if (exp_strobe[t] && m_cnt[t] != 32'hFFFF_FFFF) m_cnt[t]++;
`endif
      end
      if (running && cs && op == 2'b00 && cd[23:16] != 8'h00) m_map[cd[23:16]] = cd[TC-1:0];
      if (m_clr_left > 0) m_clr_left--;
      exp_busy = (m_clr_left > 0);
    end
    @(posedge evrClk);
    #1;
    check("strobe", 32'(triggerStrobe), 32'(exp_strobe));
    check("busy", 32'(busy), 32'(exp_busy));
    check("cntValue", cntValue, exp_cnt);
    last_strobe = triggerStrobe;
    last_cnt = cntValue;
    last_busy = busy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic ev(input logic [7:0] c);
    step(1'b0, c, 1'b1, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic cfg(input logic [31:0] d);
    step(1'b0, 8'h00, 1'b0, 1'b1, d, 4'h0);
  endtask

  function automatic logic [7:0] pick_code();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'h10;
      2:       return 8'h11;
      default: return 8'($urandom_range(1, 5));
    endcase
  endfunction

  int busy_cycles;
  logic [TC-1:0] seen;
  logic [6:0] f0, f2;

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 8'h10, 1'b1, 1'b0, 32'h0, 4'h0);
    check("busy_after_reset", 32'(busy), 32'd1);

    // Sweep: busy length, lookups and SET_MAP dropped
    busy_cycles = int'(last_busy);
    seen = '0;
    for (int i = 0; i < 300; i++) begin
      if (i == 50) cfg(set_map(8'h10, 8'hFF));
      else if (i == 100 || i == 254) ev(8'h10);
      else idle(1);
      busy_cycles += int'(last_busy);
      seen |= last_strobe;
    end
    check("busy_cycles", 32'(busy_cycles), 32'd256);
    check("sweep_strobe", 32'(seen), 32'd0);
    ev(8'h10); idle(2);
    check("clear_map_dropped", 32'(last_strobe), 32'd0);

    // Basic map and latency
    cfg(set_map(8'h10, 8'h05));
    ev(8'h10); idle(1);
    check("latency_early", 32'(last_strobe), 32'd0);
    idle(1);
    check("map_0x10", 32'(last_strobe), 32'h05);
    idle(1);
    check("single_cycle", 32'(last_strobe), 32'd0);
    ev(8'h11); idle(2);
    check("unmapped_0x11", 32'(last_strobe), 32'd0);
    cfg(set_map(8'h00, 8'hFF));
    ev(8'h00); idle(2);
    check("null_code", 32'(last_strobe), 32'd0);

    // Prescale D=3 on trigger 0
    step(1'b0, 8'h00, 1'b0, 1'b1, clr_cnt(), 4'h0);
    cfg(set_ps(4'd0, 16'd3));
    for (int i = 0; i < 9; i++) begin
      if (i < 7) ev(8'h10); else idle(1);
      if (i >= 2) begin
        f0[i-2] = last_strobe[0];
        f2[i-2] = last_strobe[2];
      end
    end
    check("prescale_t0", 32'(f0), 32'b1001001);
    check("prescale_t2", 32'(f2), 32'h7F);

    step(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 4'd0);
`ifdef EVENT_TRIGGER_COUNTERS_EN
    check("cnt0_lit", last_cnt, 32'd3);
`else
    check("cnt0_lit", last_cnt, 32'd0);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 4'd2);
`ifdef EVENT_TRIGGER_COUNTERS_EN
    check("cnt2_lit", last_cnt, 32'd7);
`else
    check("cnt2_lit", last_cnt, 32'd0);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b1, clr_cnt(), 4'd2);
    step(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 4'd0);
    check("cnt0_cleared", last_cnt, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 4'd2);
    check("cnt2_cleared", last_cnt, 32'd0);

    // Read-before-write on a same-cycle SET_MAP
    cfg(set_ps(4'd0, 16'd1));
    step(1'b0, 8'h10, 1'b1, 1'b1, set_map(8'h10, 8'h02), 4'h0);
    ev(8'h10); idle(1);
    check("rbw_old_mask", 32'(last_strobe), 32'h05);
    idle(1);
    check("rbw_new_mask", 32'(last_strobe), 32'h02);

    // SET_PRESCALE colliding with a decision suppresses the strobe
    ev(8'h10); idle(1);
    cfg(set_ps(4'd1, 16'd2));
    check("ps_collision", 32'(last_strobe), 32'd0);
    ev(8'h10); idle(2);
    check("ps_after_collision", 32'(last_strobe), 32'h02);
    ev(8'h10); idle(2);
    check("ps_d2_skip", 32'(last_strobe), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [1:0]  op;
      logic [31:0] d;
      op = 2'($urandom_range(0, 3));
      case (op)
        2'b00:   d = set_map(pick_code(), 8'($urandom));
        2'b01:   d = set_ps(4'($urandom_range(0, 9)), 16'($urandom_range(0, 4)));
        default: d = {op, 30'($urandom)};
      endcase
      step(1'b0, pick_code(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
           d, 4'($urandom_range(0, 15)));
    end

    // Reset mid-burst: in-flight events discarded, divisors back to 1
    for (int t = 0; t < TC; t++) cfg(set_ps(4'(t), 16'd3));
    cfg(set_map(8'h10, 8'hFF));
    ev(8'h10); ev(8'h10); ev(8'h10);
    step(1'b1, 8'h10, 1'b1, 1'b0, 32'h0, 4'h0);
    check("reset_strobe0", 32'(last_strobe), 32'd0);
    ev(8'h10);
    check("reset_strobe1", 32'(last_strobe), 32'd0);
    ev(8'h10);
    check("reset_strobe2", 32'(last_strobe), 32'd0);
    idle(260);
    cfg(set_map(8'h10, 8'hFF));
    for (int i = 0; i < 6; i++) begin
      if (i < 4) ev(8'h10); else idle(1);
      if (i >= 2) check("div_reset_fire", 32'(last_strobe), 32'hFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
